ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 148 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with flag update, branch resolve and sticky halt.
// Define EX_MEM_STAGE_RETIRE_CNT_EN to build the retired-instruction counter.
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [4:0]  ex_op,
  input  logic [15:0] ex_alu_o,
  input  logic        ex_cf,
  input  logic [15:0] ex_store_data,
  input  logic [2:0]  ex_rd,
  output logic        mem_valid,
  output logic [4:0]  mem_op,
  output logic [15:0] mem_alu_o,
  output logic [15:0] mem_store_data,
  output logic [2:0]  mem_rd,
  output logic        flag_cf,
  output logic        flag_zf,
  output logic        flag_nf,
  output logic        branch_taken,
  output logic [15:0] branch_target,
  output logic        halted,
  output logic [15:0] retired_cnt
);

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_ROR   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_ADDRI = 5'b10011;
  localparam logic [4:0] OP_SUBRI = 5'b10100;
  localparam logic [4:0] OP_NOT   = 5'b10101;
  localparam logic [4:0] OP_MOVR  = 5'b10110;
  localparam logic [4:0] OP_MOV   = 5'b10111;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  logic accept;
  logic load;
  logic arith;
  logic logic_op;
  logic taken;

  assign accept = en & ex_valid & ~flush & ~halted;
  assign load   = en | flush;

  // Branch conditions see the flags as they stood before this edge.
  always_comb begin
    arith    = 1'b0;
    logic_op = 1'b0;
    taken    = 1'b0;
    case (ex_op)
      OP_ADD, OP_ADDI, OP_ADDRI, OP_LDIH, OP_SUB,
      OP_SUBI, OP_SUBRI, OP_CMP, OP_ADDC, OP_SUBC:
        arith = 1'b1;
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_MOVR,
      OP_MOV, OP_SLL, OP_SRL, OP_SRA, OP_ROR:
        logic_op = 1'b1;
      OP_BZ:   taken = flag_zf;
      OP_BNZ:  taken = ~flag_zf;
      OP_BN:   taken = flag_nf;
      OP_BNN:  taken = ~flag_nf;
      OP_BC:   taken = flag_cf;
      OP_BNC:  taken = ~flag_cf;
      OP_JUMP, OP_JMPR:
        taken = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid      <= 1'b0;
      mem_op         <= OP_NOP;
      mem_alu_o      <= '0;
      mem_store_data <= '0;
      mem_rd         <= '0;
      flag_cf        <= 1'b0;
      flag_zf        <= 1'b0;
      flag_nf        <= 1'b0;
      branch_taken   <= 1'b0;
      branch_target  <= '0;
      halted         <= 1'b0;
    end else if (load) begin
      if (accept) begin
        mem_valid      <= 1'b1;
        mem_op         <= ex_op;
        mem_alu_o      <= ex_alu_o;
        mem_store_data <= ex_store_data;
        mem_rd         <= ex_rd;
      end else begin
        mem_valid      <= 1'b0;
        mem_op         <= OP_NOP;
        mem_alu_o      <= '0;
        mem_store_data <= '0;
        mem_rd         <= '0;
      end
      if (accept & arith)
        flag_cf <= ex_cf;
      if (accept & (arith | logic_op)) begin
        flag_zf <= (ex_alu_o == 16'h0000);
        flag_nf <= ex_alu_o[15];
      end
      branch_taken <= accept & taken;
      if (accept & taken)
        branch_target <= ex_alu_o;
      if (accept & (ex_op == OP_HALT))
        halted <= 1'b1;
    end
  end

`ifdef EX_MEM_STAGE_RETIRE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (accept)
      cnt_q <= cnt_q + 16'd1;
  end

  assign retired_cnt = cnt_q;
`else
  assign retired_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: directed vectors, queued expectations,
// independent monitor comparing each registered output one cycle later.
module tb_ex_mem_stage;

  localparam logic [4:0] NOP  = 5'b00000;
  localparam logic [4:0] HALT = 5'b00001;
  localparam logic [4:0] ADD  = 5'b01000;
  localparam logic [4:0] SUB  = 5'b01010;
  localparam logic [4:0] AND  = 5'b01101;
  localparam logic [4:0] XOR  = 5'b01111;
  localparam logic [4:0] JUMP = 5'b11000;
  localparam logic [4:0] BZ   = 5'b11010;
  localparam logic [4:0] BNZ  = 5'b11011;
  localparam logic [4:0] BN   = 5'b11100;
  localparam logic [4:0] BNN  = 5'b11101;
  localparam logic [4:0] BC   = 5'b11110;
  localparam logic [4:0] BNC  = 5'b11111;

  typedef struct {
    int          id;
    logic        v;
    logic [4:0]  op;
    logic [15:0] alu;
    logic [15:0] sd;
    logic [2:0]  rd;
    logic        cf;
    logic        zf;
    logic        nf;
    logic        bt;
    logic [15:0] tg;
    logic        h;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_op = 5'b0;
  logic [15:0] ex_alu_o = '0;
  logic        ex_cf = 1'b0;
  logic [15:0] ex_store_data = '0;
  logic [2:0]  ex_rd = '0;
  logic        mem_valid;
  logic [4:0]  mem_op;
  logic [15:0] mem_alu_o;
  logic [15:0] mem_store_data;
  logic [2:0]  mem_rd;
  logic        flag_cf;
  logic        flag_zf;
  logic        flag_nf;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halted;
  logic [15:0] retired_cnt;

  int   n_chk = 0;
  int   n_fail = 0;
  int   vid = 0;
  exp_t q[$];
  logic [15:0] cnt_m = '0;
  logic        h_m = 1'b0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_alu_o(ex_alu_o),
    .ex_cf(ex_cf), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_op(mem_op), .mem_alu_o(mem_alu_o),
    .mem_store_data(mem_store_data), .mem_rd(mem_rd),
    .flag_cf(flag_cf), .flag_zf(flag_zf), .flag_nf(flag_nf),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .halted(halted), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic v, input logic [4:0] op, input logic [15:0] alu,
    input logic [15:0] sd, input logic [2:0] rd,
    input logic c, input logic z, input logic n,
    input logic bt, input logic [15:0] tg, input logic h);
    exp_t x;
    x.id = 0; x.v = v; x.op = op; x.alu = alu; x.sd = sd;
    x.rd = rd; x.cf = c; x.zf = z; x.nf = n; x.bt = bt;
    x.tg = tg; x.h = h; x.cnt = '0;
    return x;
  endfunction

  task automatic chk(input string nm, input int id,
                     input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  // Monitor: one expectation per clock, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("mem_valid", x.id, {15'b0, mem_valid}, {15'b0, x.v});
      chk("mem_op", x.id, {11'b0, mem_op}, {11'b0, x.op});
      chk("mem_alu_o", x.id, mem_alu_o, x.alu);
      chk("mem_store_data", x.id, mem_store_data, x.sd);
      chk("mem_rd", x.id, {13'b0, mem_rd}, {13'b0, x.rd});
      chk("flag_cf", x.id, {15'b0, flag_cf}, {15'b0, x.cf});
      chk("flag_zf", x.id, {15'b0, flag_zf}, {15'b0, x.zf});
      chk("flag_nf", x.id, {15'b0, flag_nf}, {15'b0, x.nf});
      chk("branch_taken", x.id, {15'b0, branch_taken}, {15'b0, x.bt});
      chk("branch_target", x.id, branch_target, x.tg);
      chk("halted", x.id, {15'b0, halted}, {15'b0, x.h});
      chk("retired_cnt", x.id, retired_cnt, x.cnt);
    end
  end

  task automatic vec(input logic e, input logic fl, input logic v,
                     input logic [4:0] op, input logic [15:0] alu,
                     input logic c, input logic [15:0] sd,
                     input logic [2:0] rd, input exp_t x);
    @(negedge clk);
    rst = 1'b0;
    en = e; flush = fl; ex_valid = v; ex_op = op;
    ex_alu_o = alu; ex_cf = c; ex_store_data = sd; ex_rd = rd;
    if (e & v & ~fl & ~h_m)
      cnt_m = cnt_m + 16'd1;
    h_m = x.h;
    vid++;
    x.id = vid;
`ifdef EX_MEM_STAGE_RETIRE_CNT_EN
    x.cnt = cnt_m;
`else
    x.cnt = 16'h0000;
`endif
    q.push_back(x);
  endtask

  task automatic rst_pulse();
    exp_t x;
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_op = NOP;
    ex_alu_o = '0; ex_cf = 1'b0; ex_store_data = '0; ex_rd = '0;
    cnt_m = '0;
    h_m = 1'b0;
    x = mk(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vid++;
    x.id = vid;
    q.push_back(x);
  endtask

  initial begin
    rst_pulse();
    // ADD zero result with carry, then BZ taken
    vec(1,0,1,ADD,16'h0000,1,16'h1234,3,
        mk(1,ADD,16'h0000,16'h1234,3,1,1,0,0,16'h0000,0));
    vec(1,0,1,BZ,16'h0040,0,16'h0000,0,
        mk(1,BZ,16'h0040,16'h0000,0,1,1,0,1,16'h0040,0));
    vec(1,0,0,ADD,16'h0009,0,16'h5555,1,
        mk(0,NOP,16'h0000,16'h0000,0,1,1,0,0,16'h0040,0));
    // SUB negative, AND zero keeps cf, BC not taken
    vec(1,0,1,SUB,16'h8000,0,16'h0000,1,
        mk(1,SUB,16'h8000,16'h0000,1,0,0,1,0,16'h0040,0));
    vec(1,0,1,AND,16'h0000,1,16'h0000,2,
        mk(1,AND,16'h0000,16'h0000,2,0,1,0,0,16'h0040,0));
    vec(1,0,1,BC,16'h0100,0,16'h0000,0,
        mk(1,BC,16'h0100,16'h0000,0,0,1,0,0,16'h0040,0));
    vec(1,0,1,BNC,16'h0200,0,16'h0000,0,
        mk(1,BNC,16'h0200,16'h0000,0,0,1,0,1,16'h0200,0));
    vec(1,0,1,BN,16'h0300,0,16'h0000,0,
        mk(1,BN,16'h0300,16'h0000,0,0,1,0,0,16'h0200,0));
    // stall holds everything, then flush without enable
    vec(1,0,1,ADD,16'h0005,0,16'hAAAA,5,
        mk(1,ADD,16'h0005,16'hAAAA,5,0,0,0,0,16'h0200,0));
    vec(1,0,1,JUMP,16'h0700,0,16'h0000,0,
        mk(1,JUMP,16'h0700,16'h0000,0,0,0,0,1,16'h0700,0));
    for (int i = 0; i < 3; i++)
      vec(0,0,1,ADD,16'hFFFF,1,16'h1111,6,
          mk(1,JUMP,16'h0700,16'h0000,0,0,0,0,1,16'h0700,0));
    vec(0,1,1,ADD,16'hFFFF,1,16'h1111,6,
        mk(0,NOP,16'h0000,16'h0000,0,0,0,0,0,16'h0700,0));
    // flushed HALT must not halt; accepted HALT is sticky
    vec(1,1,1,HALT,16'h0000,0,16'h0000,0,
        mk(0,NOP,16'h0000,16'h0000,0,0,0,0,0,16'h0700,0));
    vec(1,0,1,HALT,16'h0000,0,16'h0000,0,
        mk(1,HALT,16'h0000,16'h0000,0,0,0,0,0,16'h0700,1));
    vec(1,0,1,ADD,16'h0000,1,16'h2222,4,
        mk(0,NOP,16'h0000,16'h0000,0,0,0,0,0,16'h0700,1));
    rst_pulse();
    vec(1,0,1,ADD,16'hFFFF,1,16'h3333,7,
        mk(1,ADD,16'hFFFF,16'h3333,7,1,0,1,0,16'h0000,0));
    vec(1,0,1,BNZ,16'h0800,0,16'h0000,0,
        mk(1,BNZ,16'h0800,16'h0000,0,1,0,1,1,16'h0800,0));
    vec(1,0,1,XOR,16'h0000,0,16'h0000,0,
        mk(1,XOR,16'h0000,16'h0000,0,1,1,0,0,16'h0800,0));
    vec(1,0,1,BNN,16'h0900,0,16'h0000,0,
        mk(1,BNN,16'h0900,16'h0000,0,1,1,0,1,16'h0900,0));
`ifdef EX_MEM_STAGE_RETIRE_CNT_EN
    // walk the counter to 0xFFFE, then cross the wrap
    while (cnt_m != 16'hFFFE) begin
      @(negedge clk);
      en = 1'b1; flush = 1'b0; ex_valid = 1'b1; ex_op = NOP;
      ex_alu_o = '0; ex_cf = 1'b0; ex_store_data = '0; ex_rd = '0;
      cnt_m = cnt_m + 16'd1;
    end
    for (int i = 0; i < 3; i++)
      vec(1,0,1,NOP,16'h0000,0,16'h0000,0,
          mk(1,NOP,16'h0000,16'h0000,0,1,1,0,0,16'h0900,0));
    @(negedge clk);
    ex_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("retired_wrap", vid, retired_cnt, 16'h0001);
`endif
    begin
      int budget = 20;
      while (q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (q.size() > 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL drain: %0d pending, expected 0", q.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
